// File: rtl/cpu_pkg.sv
// Shared types and constants for the FETCH/EX/WB core.
// Holds the writeback source select encoding and the core datapath widths.
package cpu_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        REGSEL_ALU = 2'd0,
        REGSEL_HI  = 2'd1,
        REGSEL_LO  = 2'd2
    } regsel_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for the asynchronous GPIO input bus.
// Synchronous active-high reset clears every stage.
module gpio_sync #(
    parameter int DW     = 32,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] chain [STAGES];

    // shift the input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= {DW{1'b0}};
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    // last stage is the synchronised value
    always_comb begin
        q = chain[STAGES-1];
    end

endmodule

// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register, HI/LO and GPIO state, register-file write port
// and EX operand forwarding selects.
module ex_wb_stage #(
    parameter int DW          = cpu_pkg::DW,
    parameter int AW          = cpu_pkg::AW,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_ex,
    input  logic          stall_ex,
    input  logic          regwrite_ex,
    input  logic [1:0]    regsel_ex,
    input  logic          enhilo_ex,
    input  logic          rdrt_ex,
    input  logic          gpio_out_ex,
    input  logic          gpio_in_ex,
    input  logic [AW-1:0] rs_addr_ex,
    input  logic [AW-1:0] rt_addr_ex,
    input  logic [AW-1:0] rd_addr_ex,
    input  logic [DW-1:0] rs_data_ex,
    input  logic [DW-1:0] lo_ex,
    input  logic [DW-1:0] hi_ex,
    input  logic [DW-1:0] gpio_in,
    output logic [DW-1:0] gpio_out,
    output logic          regwrite_wb,
    output logic [AW-1:0] writeaddr_wb,
    output logic [DW-1:0] writedata_wb,
    output logic          fwd_a,
    output logic          fwd_b
);

    import cpu_pkg::*;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic          take;
    logic [AW-1:0] dest;
    logic          regwrite_q;
    logic [AW-1:0] addr_q;
    regsel_t       regsel_q;
    logic          gin_q;
    logic [DW-1:0] lo_q;
    logic [DW-1:0] hi_r;
    logic [DW-1:0] lo_r;
    logic [DW-1:0] gpio_sync_val;

    // qualify the EX slot and pick the destination register
    always_comb begin
        take = valid_ex & ~stall_ex;
        if (rdrt_ex) begin
            dest = rt_addr_ex;
        end else begin
            dest = rd_addr_ex;
        end
    end

    // EX->WB pipeline register; a bubble only clears the write enable
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            addr_q     <= {AW{1'b0}};
            regsel_q   <= REGSEL_ALU;
            gin_q      <= 1'b0;
            lo_q       <= {DW{1'b0}};
        end else if (take) begin
            regwrite_q <= regwrite_ex & ~gpio_out_ex & (dest != ZERO_ADDR);
            addr_q     <= dest;
            regsel_q   <= regsel_t'(regsel_ex);
            gin_q      <= gpio_in_ex;
            lo_q       <= lo_ex;
        end else begin
            regwrite_q <= 1'b0;
        end
    end

    // HI/LO load on mult/multu
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= {DW{1'b0}};
            lo_r <= {DW{1'b0}};
        end else if (take && enhilo_ex) begin
            hi_r <= hi_ex;
            lo_r <= lo_ex;
        end
    end

    // GPIO output register
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= {DW{1'b0}};
        end else if (take && gpio_out_ex) begin
            gpio_out <= rs_data_ex;
        end
    end

    gpio_sync #(
        .DW     (DW),
        .STAGES (SYNC_STAGES)
    ) u_gpio_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_in),
        .q   (gpio_sync_val)
    );

    // writeback data select and register-file write port
    always_comb begin
        writedata_wb = lo_q;
        if (gin_q) begin
            writedata_wb = gpio_sync_val;
        end else begin
            case (regsel_q)
                REGSEL_HI: writedata_wb = hi_r;
                REGSEL_LO: writedata_wb = lo_r;
                default:   writedata_wb = lo_q;
            endcase
        end
        regwrite_wb  = regwrite_q;
        writeaddr_wb = addr_q;
    end

    // forward the WB result into EX; r0 is never forwarded
    always_comb begin
        fwd_a = regwrite_q & (addr_q == rs_addr_ex) & (rs_addr_ex != ZERO_ADDR);
        fwd_b = regwrite_q & (addr_q == rt_addr_ex) & (rt_addr_ex != ZERO_ADDR);
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed table-driven bench for ex_wb_stage: each row is one EX-slot
// instruction plus the WB outputs expected while that row sits in EX.
module tb_ex_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ex, stall_ex, regwrite_ex, enhilo_ex, rdrt_ex;
    logic        gpio_out_ex, gpio_in_ex;
    logic [1:0]  regsel_ex;
    logic [4:0]  rs_addr_ex, rt_addr_ex, rd_addr_ex;
    logic [31:0] rs_data_ex, lo_ex, hi_ex, gpio_in;
    logic [31:0] gpio_out, writedata_wb;
    logic        regwrite_wb, fwd_a, fwd_b;
    logic [4:0]  writeaddr_wb;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_wb_stage #(.DW(32), .AW(5), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_ex     (valid_ex),
        .stall_ex     (stall_ex),
        .regwrite_ex  (regwrite_ex),
        .regsel_ex    (regsel_ex),
        .enhilo_ex    (enhilo_ex),
        .rdrt_ex      (rdrt_ex),
        .gpio_out_ex  (gpio_out_ex),
        .gpio_in_ex   (gpio_in_ex),
        .rs_addr_ex   (rs_addr_ex),
        .rt_addr_ex   (rt_addr_ex),
        .rd_addr_ex   (rd_addr_ex),
        .rs_data_ex   (rs_data_ex),
        .lo_ex        (lo_ex),
        .hi_ex        (hi_ex),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .regwrite_wb  (regwrite_wb),
        .writeaddr_wb (writeaddr_wb),
        .writedata_wb (writedata_wb),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    typedef struct {
        logic        valid, stall, regwrite;
        logic [1:0]  regsel;
        logic        enhilo, rdrt, gout, gin;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, lo, hi, gin_val;
        logic        e_rw;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_fa, e_fb;
        logic [31:0] e_gout;
    } vec_t;

    localparam logic [31:0] A5 = 32'hA5A5_A5A5;
    localparam logic [31:0] FE = 32'hFFFF_FFFE;
    localparam logic [31:0] GI = 32'h0000_1234;

    vec_t tbl [19];

    function automatic vec_t v(
        input logic valid, stall, regwrite, input logic [1:0] regsel,
        input logic enhilo, rdrt, gout, gin,
        input logic [4:0] rs, rt, rd,
        input logic [31:0] rs_data, lo, hi, gin_val,
        input logic e_rw, input logic [4:0] e_addr, input logic [31:0] e_data,
        input logic e_fa, e_fb, input logic [31:0] e_gout);
        vec_t r;
        r.valid = valid; r.stall = stall; r.regwrite = regwrite; r.regsel = regsel;
        r.enhilo = enhilo; r.rdrt = rdrt; r.gout = gout; r.gin = gin;
        r.rs = rs; r.rt = rt; r.rd = rd;
        r.rs_data = rs_data; r.lo = lo; r.hi = hi; r.gin_val = gin_val;
        r.e_rw = e_rw; r.e_addr = e_addr; r.e_data = e_data;
        r.e_fa = e_fa; r.e_fb = e_fb; r.e_gout = e_gout;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        valid_ex    = t.valid;
        stall_ex    = t.stall;
        regwrite_ex = t.regwrite;
        regsel_ex   = t.regsel;
        enhilo_ex   = t.enhilo;
        rdrt_ex     = t.rdrt;
        gpio_out_ex = t.gout;
        gpio_in_ex  = t.gin;
        rs_addr_ex  = t.rs;
        rt_addr_ex  = t.rt;
        rd_addr_ex  = t.rd;
        rs_data_ex  = t.rs_data;
        lo_ex       = t.lo;
        hi_ex       = t.hi;
        gpio_in     = t.gin_val;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_row(input string tag, input vec_t t);
        check({tag, " regwrite_wb"},  {31'd0, regwrite_wb}, {31'd0, t.e_rw});
        check({tag, " writeaddr_wb"}, {27'd0, writeaddr_wb}, {27'd0, t.e_addr});
        check({tag, " writedata_wb"}, writedata_wb, t.e_data);
        check({tag, " fwd_a"},        {31'd0, fwd_a}, {31'd0, t.e_fa});
        check({tag, " fwd_b"},        {31'd0, fwd_b}, {31'd0, t.e_fb});
        check({tag, " gpio_out"},     gpio_out, t.e_gout);
    endtask

    vec_t bub;

    initial begin
        bub = v(1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0,
                32'd0,32'd0,32'd0,32'd0, 1'b0,5'd0,32'd0,1'b0,1'b0,32'd0);
        //                valid stall rw  sel   hilo rdrt gout gin   rs    rt    rd     rs_data lo           hi     gpio_in  e_rw e_addr e_data  fa   fb   e_gout
        tbl[0]  = v(1'b1,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd1, 5'd2, 5'd5,  32'd0, 32'd7,      32'd0, 32'd0, 1'b0,5'd0, 32'd0, 1'b0,1'b0,32'd0);
        tbl[1]  = v(1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd5, 5'd0, 5'd0,  32'd0, 32'd0,      32'd0, 32'd0, 1'b1,5'd5, 32'd7, 1'b1,1'b0,32'd0);
        tbl[2]  = v(1'b1,1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0,  32'd0, FE,         32'd1, 32'd0, 1'b0,5'd5, 32'd7, 1'b0,1'b0,32'd0);
        tbl[3]  = v(1'b1,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd3,  32'd0, 32'd0,      32'd0, 32'd0, 1'b0,5'd0, FE,    1'b0,1'b0,32'd0);
        tbl[4]  = v(1'b1,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd4,  32'd0, 32'd0,      32'd0, 32'd0, 1'b1,5'd3, 32'd1, 1'b0,1'b0,32'd0);
        tbl[5]  = v(1'b1,1'b0,1'b1,2'd0,1'b0,1'b0,1'b1,1'b0, 5'd0, 5'd0, 5'd7,  A5,    32'd0,      32'd0, 32'd0, 1'b1,5'd4, FE,    1'b0,1'b0,32'd0);
        tbl[6]  = v(1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd7, 5'd0, 5'd0,  32'd0, 32'd0,      32'd0, GI,    1'b0,5'd7, 32'd0, 1'b0,1'b0,A5);
        tbl[7]  = v(1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0,  32'd0, 32'd0,      32'd0, GI,    1'b0,5'd7, 32'd0, 1'b0,1'b0,A5);
        tbl[8]  = v(1'b1,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b1, 5'd0, 5'd0, 5'd9,  32'd0, 32'd0,      32'd0, GI,    1'b0,5'd7, 32'd0, 1'b0,1'b0,A5);
        tbl[9]  = v(1'b1,1'b0,1'b1,2'd0,1'b0,1'b1,1'b0,1'b0, 5'd0, 5'd8, 5'd2,  32'd0, 32'h64,     32'd0, GI,    1'b1,5'd9, GI,    1'b0,1'b0,A5);
        tbl[10] = v(1'b1,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd8, 5'd8, 5'd10, 32'd0, 32'd0,      32'd0, GI,    1'b1,5'd8, 32'h64,1'b1,1'b1,A5);
        tbl[11] = v(1'b1,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0,  32'd0, 32'h55,     32'd0, GI,    1'b1,5'd10,32'd0, 1'b0,1'b0,A5);
        tbl[12] = v(1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0,  32'd0, 32'd0,      32'd0, GI,    1'b0,5'd0, 32'h55,1'b0,1'b0,A5);
        tbl[13] = v(1'b1,1'b1,1'bx,2'bxx,1'b1,1'bx,1'b1,1'bx,5'd0, 5'd0, 5'bx,  'x,    'x,         'x,    GI,    1'b0,5'd0, 32'h55,1'b0,1'b0,A5);
        tbl[14] = v(1'b1,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd3,  32'd0, 32'd0,      32'd0, GI,    1'b0,5'd0, 32'h55,1'b0,1'b0,A5);
        tbl[15] = v(1'b1,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd4,  32'd0, 32'd0,      32'd0, GI,    1'b1,5'd3, 32'd1, 1'b0,1'b0,A5);
        tbl[16] = v(1'b1,1'b0,1'b0,2'd0,1'b1,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0,  32'd0, 32'd3,      32'd2, GI,    1'b1,5'd4, FE,    1'b0,1'b0,A5);
        tbl[17] = v(1'b1,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd3,  32'd0, 32'd0,      32'd0, GI,    1'b0,5'd0, 32'd3, 1'b0,1'b0,A5);
        tbl[18] = v(1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd0, 5'd0, 5'd0,  32'd0, 32'd0,      32'd0, GI,    1'b1,5'd3, 32'd2, 1'b0,1'b0,A5);

        // reset state
        rst = 1'b1;
        drive(bub);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_row("reset", bub);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i]);
            #1;
            check_row($sformatf("row%0d", i), tbl[i]);
            @(negedge clk);
        end

        // reset one cycle after an add discards it and clears HI/LO and GPIO out
        drive(v(1'b1,1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd5,
                32'd0,32'd7,32'd0,GI, 1'b0,5'd0,32'd0,1'b0,1'b0,32'd0));
        @(negedge clk);
        drive(bub);
        #1;
        check("pre-reset regwrite_wb", {31'd0, regwrite_wb}, 32'd1);
        check("pre-reset writedata_wb", writedata_wb, 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset regwrite_wb", {31'd0, regwrite_wb}, 32'd0);
        check("post-reset gpio_out", gpio_out, 32'd0);
        check("post-reset writedata_wb", writedata_wb, 32'd0);
        drive(v(1'b1,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd3,
                32'd0,32'd0,32'd0,GI, 1'b0,5'd0,32'd0,1'b0,1'b0,32'd0));
        @(negedge clk);
        drive(v(1'b1,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0, 5'd0,5'd0,5'd4,
                32'd0,32'd0,32'd0,GI, 1'b0,5'd0,32'd0,1'b0,1'b0,32'd0));
        #1;
        check("post-reset mfhi addr", {27'd0, writeaddr_wb}, 32'd3);
        check("post-reset hi_r", writedata_wb, 32'd0);
        @(negedge clk);
        drive(bub);
        #1;
        check("post-reset mflo addr", {27'd0, writeaddr_wb}, 32'd4);
        check("post-reset lo_r", writedata_wb, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Pipeline register and writeback logic between EX and the register file in the 3-stage (FETCH/EX/WB) core.
- Captures the EX-stage control bundle and ALU results, and owns the HI/LO registers and the GPIO output register.
- Synchronises GPIO input and drives the single register-file write port.
- Provides EX-operand forwarding selects so back-to-back dependent instructions need no stall.

Parameters:
- DW, 32, datapath width
- AW, 5, register address width
- SYNC_STAGES, 2, GPIO input synchroniser depth (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_ex  in  1  EX holds a real instruction (0 = bubble)
- stall_ex  in  1  EX squashed this cycle; treated as bubble
- regwrite_ex  in  1  control: write register file
- regsel_ex  in  2  control: 0 ALU lo, 1 HI (mfhi), 2 LO (mflo)
- enhilo_ex  in  1  control: load HI/LO (mult/multu)
- rdrt_ex  in  1  control: 1 dest = rt, 0 dest = rd
- gpio_out_ex  in  1  control: GPIO write instruction
- gpio_in_ex  in  1  control: GPIO read instruction
- rs_addr_ex  in  AW  instr[25:21]
- rt_addr_ex  in  AW  instr[20:16]
- rd_addr_ex  in  AW  instr[15:11]
- rs_data_ex  in  DW  register-file read data 1 (GPIO write value)
- lo_ex  in  DW  ALU low result
- hi_ex  in  DW  ALU high result
- gpio_in  in  DW  asynchronous external input
- gpio_out  out  DW  GPIO output register
- regwrite_wb  out  1  register-file write enable
- writeaddr_wb  out  AW  register-file write address
- writedata_wb  out  DW  register-file write data
- fwd_a  out  1  forward writedata_wb to ALU operand A (rs)
- fwd_b  out  1  forward writedata_wb to ALU operand B (rt)

Behaviour:
- Reset, synchronous, wins over all other inputs: every flop clears to 0. Outputs gpio_out, regwrite_wb, writeaddr_wb, fwd_a and fwd_b are 0. writedata_wb is 0, since all its mux inputs are 0.
- Qualification: take = valid_ex & ~stall_ex. All control inputs are don't-care (X permitted) when take = 0. No register may change from an X control value.
- Latency: 1 cycle. An instruction in EX at cycle N drives the WB outputs during cycle N+1.
- At each posedge with take = 1:
  - regwrite_q <= regwrite_ex & ~gpio_out_ex & (dest != 0), where dest = rdrt_ex ? rt_addr_ex : rd_addr_ex.
  - addr_q <= dest; regsel_q <= regsel_ex; gin_q <= gpio_in_ex; lo_q <= lo_ex.
- At each posedge with take = 0: regwrite_q <= 0. Other WB registers hold.
- HI/LO: hi_r <= hi_ex and lo_r <= lo_ex only when take & enhilo_ex. Otherwise they hold. mfhi/mflo immediately after mult reads the new value, because HI/LO update at the same edge that the mfhi/mflo instruction enters WB's predecessor.
- GPIO out: gpio_out <= rs_data_ex when take & gpio_out_ex. Otherwise it holds. The register file is never written by a GPIO write.
- GPIO in: gpio_in passes through a SYNC_STAGES flop chain. gpio_sync is the last stage.
- writedata_wb is combinational from WB registers:
  - gin_q → gpio_sync
  - else regsel_q = 1 → hi_r
  - else regsel_q = 2 → lo_r
  - else (0 or 3) → lo_q
- regwrite_wb = regwrite_q; writeaddr_wb = addr_q.
- Forwarding (combinational):
  - fwd_a = regwrite_q & (addr_q == rs_addr_ex) & (rs_addr_ex != 0).
  - fwd_b is the same with rt_addr_ex.
  - Both are independent of valid_ex.
- Simultaneous cases:
  - mult in EX while mfhi in WB: WB outputs the old hi_r this cycle. The new value is visible from the next cycle.
  - GPIO write with regwrite_ex = 1: the write is suppressed.
- Reset mid-stream: the in-flight WB instruction is discarded (regwrite_wb = 0 the cycle after reset). HI/LO and gpio_out are lost.

Decomposition:
- Package cpu_pkg:
  - regsel_t enum: REGSEL_ALU = 2'd0, REGSEL_HI = 2'd1, REGSEL_LO = 2'd2.
  - Localparams DW, AW, REG_ZERO = 5'd0.
- One sub-module, gpio_sync: parameterised DW × SYNC_STAGES flop chain with synchronous reset.

Test Plan:
- add in EX, rd = 5, lo_ex = 32'h0000_0007, take = 1 → next cycle regwrite_wb = 1, writeaddr_wb = 5, writedata_wb = 7. Cycle after (bubble) regwrite_wb = 0.
- mult with hi_ex = 32'h1, lo_ex = 32'hFFFF_FFFE, then mfhi (rd = 3), then mflo (rd = 4) → writes r3 = 32'h1, r4 = 32'hFFFF_FFFE. No regwrite for the mult.
- GPIO write (gpio_out_ex = 1, regwrite_ex = 1, rs_data_ex = 32'hA5A5_A5A5) → gpio_out = A5A5_A5A5 after the edge, regwrite_wb = 0. Then a GPIO read with gpio_in = 32'h1234 held ≥ SYNC_STAGES cycles → writedata_wb = 32'h1234.
- addi rt = 8 (rdrt_ex = 1), then a dependent instruction in EX with rs_addr_ex = 8 and rt_addr_ex = 8 → fwd_a = fwd_b = 1. Destination r0 → regwrite_wb = 0 and fwd_a = 0.
- stall_ex = 1 with enhilo_ex = 1 and gpio_out_ex = 1, controls driven X → HI/LO and gpio_out unchanged, regwrite_wb = 0, no X on any output.
- rst asserted one cycle after add → regwrite_wb = 0, gpio_out = 0, hi_r = lo_r = 0 on the following cycle.
